// File: rtl/pmp_pkg.sv
// Shared definitions for the pattern-matching bridge: register map, command
// word layout, dispatcher states and a byte-lane helper.
package pmp_pkg;

  // Word offsets (daddr[5:2]) inside the 64-byte register window.
  localparam logic [3:0] OFF_CMD    = 4'h8;
  localparam logic [3:0] OFF_STATUS = 4'h9;
  localparam logic [3:0] OFF_DACC   = 4'hA;
  localparam logic [3:0] OFF_PACC   = 4'hB;
  localparam logic [3:0] OFF_IRQ_EN = 4'hC;

  // Command word layout: bcast at the top, ctrl packed just below it, target in the low byte.
  localparam int CMD_BCAST_BIT = 31;
  localparam int CMD_CTRL_MSB  = 30;
  localparam int CMD_TGT_W     = 8;

  localparam logic [1:0] OP_NOP = 2'b00;

  localparam int ST_OVF_BIT = 8;
  localparam int ST_ERR_BIT = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } disp_state_t;

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{be[b]}};
    return m;
  endfunction

endpackage

// File: rtl/pmp_cmd_fifo.sv
// Command FIFO for the bridge. Pushes into a full FIFO are dropped; the read
// port shows the head entry combinationally.
module pmp_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pmp_bridge.sv
// Memory-mapped bridge that queues commands from a 32-bit bus and dispatches
// them to N_MOD pattern-matching channels, with sticky accept/pattern flags and an irq.
module pmp_bridge
  import pmp_pkg::*;
#(
  parameter int          N_MOD      = 4,
  parameter int          DATA_W     = 64,
  parameter int          CTRL_W     = 16,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0040_0000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               daddr,
  input  logic [31:0]               dwdata,
  input  logic [3:0]                dwe,
  output logic [31:0]               drdata,
  output logic [N_MOD*DATA_W-1:0]   pmp_data,
  output logic [N_MOD*CTRL_W-1:0]   pmp_control,
  output logic [N_MOD-1:0]          pmp_valid,
  input  logic [N_MOD-1:0]          pmp_data_acc,
  input  logic [N_MOD-1:0]          pmp_pattern_acc,
  output logic                      irq
);

  localparam int NW    = DATA_W / 32;
  localparam int CMD_W = 1 + CTRL_W + CMD_TGT_W + DATA_W;
  localparam int FCW   = $clog2(FIFO_DEPTH + 1);

  logic                     in_win;
  logic [3:0]               woff;
  logic                     wr_en;
  logic [31:0]              wmask;
  logic [31:0]              wbits;
  logic                     wr_status, wr_dacc, wr_pacc, wr_irq_en;
  logic                     unused_addr;

  logic [NW-1:0][31:0]      dbuf;
  logic [N_MOD-1:0]         dacc, pacc, irq_en;
  logic                     ovf, err;

  disp_state_t              state;
  logic [CMD_W-1:0]         cmd_q, fifo_rdata;
  logic                     push_req, fifo_pop, fifo_full, fifo_empty;
  logic [FCW-1:0]           fifo_count;

  logic                     cmd_bcast;
  logic [CTRL_W-1:0]        cmd_ctrl;
  logic [CMD_TGT_W-1:0]     cmd_tgt;
  logic [DATA_W-1:0]        cmd_data;
  logic                     tgt_bad, is_nop, err_set;
  logic [N_MOD-1:0]         sel, handshake;

  logic [N_MOD-1:0][DATA_W-1:0] data_r;
  logic [N_MOD-1:0][CTRL_W-1:0] ctrl_r;

  assign in_win      = (daddr[31:6] == BASE_ADDR[31:6]);
  assign woff        = daddr[5:2];
  assign unused_addr = ^daddr[1:0];
  assign wr_en       = in_win && (dwe != 4'h0);
  assign wmask       = lane_mask(dwe);
  assign wbits       = dwdata & wmask;
  assign wr_status   = wr_en && (woff == OFF_STATUS);
  assign wr_dacc     = wr_en && (woff == OFF_DACC);
  assign wr_pacc     = wr_en && (woff == OFF_PACC);
  assign wr_irq_en   = wr_en && (woff == OFF_IRQ_EN);

  assign push_req = wr_en && (woff == OFF_CMD) && (dwe == 4'hF);
  assign fifo_pop = (state == ST_IDLE) && !fifo_empty;

  pmp_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .wdata ({dwdata[CMD_BCAST_BIT], dwdata[CMD_CTRL_MSB -: CTRL_W], dwdata[CMD_TGT_W-1:0], dbuf}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign {cmd_bcast, cmd_ctrl, cmd_tgt, cmd_data} = cmd_q;
  assign tgt_bad   = !cmd_bcast && ({24'd0, cmd_tgt} >= 32'(N_MOD));
  assign is_nop    = (cmd_ctrl[CTRL_W-1 -: 2] == OP_NOP);
  assign err_set   = (state == ST_ISSUE) && tgt_bad;
  assign handshake = pmp_valid & pmp_data_acc;

  always_comb begin
    sel = '0;
    for (int i = 0; i < N_MOD; i++) sel[i] = cmd_bcast || (cmd_tgt == CMD_TGT_W'(i));
  end

  // Channel handshake: a transfer on channel i happens at a rising edge where
  // pmp_valid[i] and pmp_data_acc[i] are both high; until then pmp_valid[i],
  // pmp_data and pmp_control of that channel hold, and acc with valid low is ignored.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cmd_q     <= '0;
      data_r    <= '0;
      ctrl_r    <= '0;
      pmp_valid <= '0;
    end else begin
      pmp_valid <= pmp_valid & ~pmp_data_acc;
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            cmd_q <= fifo_rdata;
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= ST_IDLE;
          if (!tgt_bad) begin
            for (int i = 0; i < N_MOD; i++) begin
              if (sel[i]) begin
                data_r[i] <= cmd_data;
                ctrl_r[i] <= cmd_ctrl;
              end
            end
            if (!is_nop) begin
              pmp_valid <= sel;
              state     <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (pmp_valid == '0) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign pmp_data    = data_r;
  assign pmp_control = ctrl_r;

  // Sticky flags: the set term is OR-ed in after the clear so a simultaneous set survives.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dbuf   <= '0;
      dacc   <= '0;
      pacc   <= '0;
      irq_en <= '0;
      ovf    <= 1'b0;
      err    <= 1'b0;
      irq    <= 1'b0;
    end else begin
      for (int w = 0; w < NW; w++) begin
        if (wr_en && (woff == 4'(w))) dbuf[w] <= (dbuf[w] & ~wmask) | wbits;
      end
      dacc <= (dacc & ~({N_MOD{wr_dacc}} & wbits[N_MOD-1:0])) | handshake;
      pacc <= (pacc & ~({N_MOD{wr_pacc}} & wbits[N_MOD-1:0])) | pmp_pattern_acc;
      if (wr_irq_en) irq_en <= (irq_en & ~wmask[N_MOD-1:0]) | wbits[N_MOD-1:0];
      ovf <= (ovf & ~(wr_status & wbits[ST_OVF_BIT])) | (push_req & fifo_full);
      err <= (err & ~(wr_status & wbits[ST_ERR_BIT])) | err_set;
      irq <= |(pacc & irq_en);
    end
  end

  always_comb begin
    drdata = '0;
    if (in_win && (dwe == 4'h0)) begin
      for (int w = 0; w < NW; w++) begin
        if (woff == 4'(w)) drdata = dbuf[w];
      end
      case (woff)
        OFF_STATUS: drdata = {22'd0, err, ovf, 5'(fifo_count), (state != ST_IDLE),
                              fifo_full, fifo_empty};
        OFF_DACC:   drdata = 32'(dacc);
        OFF_PACC:   drdata = 32'(pacc);
        OFF_IRQ_EN: drdata = 32'(irq_en);
        default:    ;
      endcase
    end
  end

endmodule

// File: tb/tb_pmp_bridge.sv
// Directed bench for pmp_bridge: a queue-based model of the command path
// checked every cycle, plus literal register and channel checks per scenario.
module tb_pmp_bridge;

  localparam int N     = 4;
  localparam int DW    = 64;
  localparam int CW    = 16;
  localparam int DEPTH = 4;
  localparam int EW    = 1 + CW + 8 + DW;
  localparam logic [31:0] BASE = 32'h0040_0000;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [31:0]     daddr = '0;
  logic [31:0]     dwdata = '0;
  logic [3:0]      dwe = '0;
  logic [31:0]     drdata;
  logic [N*DW-1:0] pmp_data;
  logic [N*CW-1:0] pmp_control;
  logic [N-1:0]    pmp_valid;
  logic [N-1:0]    pmp_data_acc = '0;
  logic [N-1:0]    pmp_pattern_acc = '0;
  logic            irq;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  pmp_bridge #(
    .N_MOD      (N),
    .DATA_W     (DW),
    .CTRL_W     (CW),
    .FIFO_DEPTH (DEPTH),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .daddr           (daddr),
    .dwdata          (dwdata),
    .dwe             (dwe),
    .drdata          (drdata),
    .pmp_data        (pmp_data),
    .pmp_control     (pmp_control),
    .pmp_valid       (pmp_valid),
    .pmp_data_acc    (pmp_data_acc),
    .pmp_pattern_acc (pmp_pattern_acc),
    .irq             (irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] m_cur;
  int            m_stage;   // 0 nothing in flight, 1 command just taken, 2 waiting for accepts
  logic [N-1:0]  m_valid, m_dacc, m_pacc, m_irqen;
  logic          m_irq, m_ovf, m_err;
  logic [DW-1:0] m_data [N];
  logic [CW-1:0] m_ctrl [N];
  logic [31:0]   m_dbuf [2];

  always @(posedge clk) begin
    logic          hit;
    logic [3:0]    wo;
    logic [31:0]   bm, wb;
    logic          bc;
    logic [CW-1:0] c;
    logic [7:0]    t;
    logic [DW-1:0] d;
    int            pre_size;
    if (!reset) begin
      exp_q.delete();
      m_stage = 0;
      m_valid = '0; m_dacc = '0; m_pacc = '0; m_irqen = '0;
      m_irq = 1'b0; m_ovf = 1'b0; m_err = 1'b0;
      m_dbuf[0] = '0; m_dbuf[1] = '0;
      for (int i = 0; i < N; i++) begin
        m_data[i] = '0;
        m_ctrl[i] = '0;
      end
    end else begin
      hit = (daddr[31:6] == BASE[31:6]) && (dwe != 4'h0);
      wo  = daddr[5:2];
      bm  = {{8{dwe[3]}}, {8{dwe[2]}}, {8{dwe[1]}}, {8{dwe[0]}}};
      wb  = dwdata & bm;
      pre_size = exp_q.size();

      m_irq = |(m_pacc & m_irqen);
      for (int i = 0; i < N; i++) begin
        if (hit && wo == 4'hA && wb[i]) m_dacc[i] = 1'b0;
        if (m_valid[i] && pmp_data_acc[i]) m_dacc[i] = 1'b1;
        if (hit && wo == 4'hB && wb[i]) m_pacc[i] = 1'b0;
        if (pmp_pattern_acc[i]) m_pacc[i] = 1'b1;
        if (hit && wo == 4'hC && bm[i]) m_irqen[i] = wb[i];
      end
      if (hit && wo == 4'h9) begin
        if (wb[8]) m_ovf = 1'b0;
        if (wb[9]) m_err = 1'b0;
      end

      if (m_stage == 2) begin
        if (m_valid == '0) m_stage = 0;
        m_valid = m_valid & ~pmp_data_acc;
      end else if (m_stage == 1) begin
        {bc, c, t, d} = m_cur;
        m_stage = 0;
        if (!bc && t >= N) m_err = 1'b1;
        else begin
          for (int i = 0; i < N; i++) begin
            if (bc || t == i) begin
              m_data[i] = d;
              m_ctrl[i] = c;
              if (c[CW-1:CW-2] != 2'b00) begin
                m_valid[i] = 1'b1;
                m_stage = 2;
              end
            end
          end
        end
      end else if (exp_q.size() > 0) begin
        m_cur = exp_q.pop_front();
        m_stage = 1;
      end

      if (hit && wo == 4'h8 && dwe == 4'hF) begin
        if (pre_size == DEPTH) m_ovf = 1'b1;
        else exp_q.push_back({dwdata[31], dwdata[30:15], dwdata[7:0], m_dbuf[1], m_dbuf[0]});
      end
      if (hit && wo < 4'd2) m_dbuf[wo[0]] = (m_dbuf[wo[0]] & ~bm) | wb;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [N*DW-1:0] ed;
    logic [N*CW-1:0] ec;
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        ed[i*DW +: DW] = m_data[i];
        ec[i*CW +: CW] = m_ctrl[i];
      end
      chk("m_valid", pmp_valid, m_valid);
      chk("m_data", pmp_data, ed);
      chk("m_control", pmp_control, ec);
      chk("m_irq", irq, m_irq);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wr(input logic [31:0] a, input logic [31:0] v, input logic [3:0] be);
    daddr = a; dwdata = v; dwe = be;
    @(posedge clk); #1;
    dwe = 4'h0;
  endtask

  task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string name);
    daddr = a; dwe = 4'h0;
    @(negedge clk); #1;
    chk(name, drdata, exp);
    @(posedge clk); #1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    step(2);
    chk_en = 1'b1;
    wr(BASE + 32'h00, 32'hDEAD_BEEF, 4'hF);   // lands while reset is low
    reset = 1'b1;
    rd_chk(BASE + 32'h00, 32'h0, "dbuf_after_reset");
    rd_chk(BASE + 32'h24, 32'h1, "status_reset");
    rd_chk(BASE + 32'h30, 32'h0, "irq_en_reset");
    pmp_data_acc = 4'hF;
    step(1);
    pmp_data_acc = 4'h0;
    rd_chk(BASE + 32'h28, 32'h0, "dacc_ignored_acc");

    // single-channel command
    wr(BASE + 32'h00, 32'h5566_7788, 4'hF);
    wr(BASE + 32'h04, 32'h1122_3344, 4'hF);
    wr(BASE + 32'h20, 32'h2000_8001, 4'hF);
    step(1);
    chk("valid_at_pop", pmp_valid, 4'b0000);
    step(1);
    chk("valid_issue", pmp_valid, 4'b0010);
    chk("ch1_data", pmp_data[127:64], 64'h1122_3344_5566_7788);
    chk("ch1_ctrl", pmp_control[31:16], 16'h4001);
    pmp_data_acc = 4'b0010;
    step(1);
    pmp_data_acc = 4'b0000;
    chk("valid_after_acc", pmp_valid, 4'b0000);
    rd_chk(BASE + 32'h28, 32'h2, "dacc_ch1");
    rd_chk(BASE + 32'h24, 32'h1, "status_idle");
    wr(BASE + 32'h28, 32'h2, 4'hF);
    rd_chk(BASE + 32'h28, 32'h0, "dacc_w1c");

    // byte lanes, unmapped space, partial CMD
    wr(BASE + 32'h00, 32'hFFFF_FFFF, 4'b0101);
    rd_chk(BASE + 32'h00, 32'h55FF_77FF, "dbuf_lanes");
    wr(BASE + 32'h08, 32'h1234_5678, 4'hF);
    rd_chk(BASE + 32'h08, 32'h0, "dbuf_unused_word");
    rd_chk(BASE + 32'h34, 32'h0, "unmapped");
    rd_chk(BASE + 32'h20, 32'h0, "cmd_reads_zero");
    rd_chk(BASE + 32'h40, 32'h0, "outside_window");
    wr(BASE + 32'h20, 32'h2000_8001, 4'h7);
    step(3);
    rd_chk(BASE + 32'h24, 32'h1, "partial_cmd_ignored");

    // broadcast with staggered accepts: ch0@2 (and a stray @4), ch1@5, ch2@3, ch3@7
    wr(BASE + 32'h00, 32'hAAAA_0001, 4'hF);
    wr(BASE + 32'h04, 32'hBBBB_0002, 4'hF);
    wr(BASE + 32'h20, 32'hC000_0000, 4'hF);
    step(2);
    chk("bcast_valid", pmp_valid, 4'hF);
    chk("bcast_data", pmp_data, {4{64'hBBBB_0002_AAAA_0001}});
    chk("bcast_ctrl", pmp_control, {4{16'h8000}});
    for (int k = 1; k <= 7; k++) begin
      pmp_data_acc = {(k == 7), (k == 3), (k == 5), (k == 2) || (k == 4)};
      step(1);
    end
    pmp_data_acc = 4'h0;
    chk("bcast_all_dropped", pmp_valid, 4'h0);
    rd_chk(BASE + 32'h24, 32'h5, "busy_at_last_acc");
    rd_chk(BASE + 32'h24, 32'h1, "busy_cleared");
    rd_chk(BASE + 32'h28, 32'hF, "dacc_all");
    wr(BASE + 32'h28, 32'hF, 4'hF);

    // overflow: dispatcher parked in WAIT, then five pushes
    wr(BASE + 32'h20, 32'h4000_0000, 4'hF);
    step(2);
    for (int i = 0; i < 5; i++) wr(BASE + 32'h20, 32'h4000_0000 + (i << 16), 4'hF);
    rd_chk(BASE + 32'h24, 32'h126, "status_full_ovf");
    wr(BASE + 32'h24, 32'h100, 4'hF);
    rd_chk(BASE + 32'h24, 32'h026, "ovf_w1c");
    pmp_data_acc = 4'b0001;
    step(30);
    pmp_data_acc = 4'b0000;
    rd_chk(BASE + 32'h24, 32'h1, "drained");
    rd_chk(BASE + 32'h28, 32'h1, "dacc_ch0");
    wr(BASE + 32'h28, 32'h1, 4'hF);

    // bad target, then NOP
    wr(BASE + 32'h20, 32'h2000_8009, 4'hF);
    step(3);
    chk("bad_tgt_valid", pmp_valid, 4'h0);
    rd_chk(BASE + 32'h24, 32'h201, "status_err");
    wr(BASE + 32'h24, 32'h200, 4'hF);
    rd_chk(BASE + 32'h24, 32'h1, "err_w1c");
    wr(BASE + 32'h00, 32'h0C0C_0C0C, 4'hF);
    wr(BASE + 32'h20, 32'h091A_0002, 4'hF);
    step(3);
    chk("nop_ctrl", pmp_control[47:32], 16'h1234);
    chk("nop_data", pmp_data[191:128], 64'hBBBB_0002_0C0C_0C0C);
    chk("nop_valid", pmp_valid, 4'h0);

    // pattern flags and irq
    wr(BASE + 32'h30, 32'h4, 4'hF);
    pmp_pattern_acc = 4'b0100;
    step(1);
    pmp_pattern_acc = 4'b0000;
    step(1);
    chk("irq_set", irq, 1'b1);
    rd_chk(BASE + 32'h2C, 32'h4, "pacc_set");
    pmp_pattern_acc = 4'b0100;
    wr(BASE + 32'h2C, 32'h4, 4'hF);
    pmp_pattern_acc = 4'b0000;
    rd_chk(BASE + 32'h2C, 32'h4, "pacc_set_wins");
    wr(BASE + 32'h2C, 32'h4, 4'hF);
    rd_chk(BASE + 32'h2C, 32'h0, "pacc_w1c");
    chk("irq_clear", irq, 1'b0);
    pmp_pattern_acc = 4'b0010;
    step(1);
    pmp_pattern_acc = 4'b0000;
    step(2);
    chk("irq_masked", irq, 1'b0);
    rd_chk(BASE + 32'h2C, 32'h2, "pacc_ch1");
    wr(BASE + 32'h2C, 32'hF, 4'hF);

    // reset during WAIT with two queued commands
    wr(BASE + 32'h20, 32'h4000_0000, 4'hF);
    step(2);
    wr(BASE + 32'h20, 32'h4000_0001, 4'hF);
    wr(BASE + 32'h20, 32'h4000_0002, 4'hF);
    chk("pre_reset_valid", pmp_valid, 4'b0001);
    reset = 1'b0;
    step(1);
    chk("reset_valid", pmp_valid, 4'h0);
    rd_chk(BASE + 32'h24, 32'h1, "reset_status");
    reset = 1'b1;
    rd_chk(BASE + 32'h24, 32'h1, "idle_after_reset");
    rd_chk(BASE + 32'h04, 32'h0, "dbuf1_reset");
    rd_chk(BASE + 32'h30, 32'h0, "irq_en_cleared");
    step(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
